exu_mul_wb: RTL and testbench

Multiply-result writeback tracker and buffer, directly downstream of the E1–E3 multiply pipeline.
- Shadows each accepted multiply through E1/E2/E3 with its destination register and tag, under the same freeze/flush rules as the multiplier.
- Captures the 32-bit E3 result into a small FIFO and presents it to the register-file writeback arbiter over a valid/ready handshake.
- Drives issue back-pressure so the FIFO can never overflow.

---
 rtl/exu_mul_wb_if.sv | 25 ++
 rtl/exu_mul_wb.sv | 101 ++++++++++
 tb/tb_exu_mul_wb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/exu_mul_wb_if.sv
// Issue and writeback handshake bundle between the multiply issue logic,
// the writeback tracker and the register-file writeback arbiter.
interface exu_mul_wb_if #(
  parameter int TAGW = 4
);
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [TAGW-1:0] issue_tag;
  logic            issue_ready;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [TAGW-1:0] wb_tag;
  logic [31:0]     wb_data;
  logic            wb_ready;

  modport master (
    output issue_valid, issue_rd, issue_tag, wb_ready,
    input  issue_ready, wb_valid, wb_rd, wb_tag, wb_data
  );

  modport slave (
    input  issue_valid, issue_rd, issue_tag, wb_ready,
    output issue_ready, wb_valid, wb_rd, wb_tag, wb_data
  );
endinterface

// File: rtl/exu_mul_wb.sv
// Multiply writeback tracker: shadows E1..E3 with {valid, rd, tag}, buffers
// E3 results in a small FIFO and throttles issue so the FIFO never overflows.
module exu_mul_wb #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         flush,
  input  logic [31:0]  mul_out,
  exu_mul_wb_if.slave  bus,
  output logic [3:0]   pending_cnt,
  output logic         err_overflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic            vld_p0, vld_p1, vld_p2;
  logic [4:0]      rd_p0, rd_p1, rd_p2;
  logic [TAGW-1:0] tag_p0, tag_p1, tag_p2;

  logic [4:0]      mem_rd   [DEPTH];
  logic [TAGW-1:0] mem_tag  [DEPTH];
  logic [31:0]     mem_data [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [3:0]      count;

  logic ready, accept, push, pop, full, wr_en, head_vld;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit is derived purely from registered state.
  assign pending_cnt = 4'(vld_p0) + 4'(vld_p1) + 4'(vld_p2) + count;
  assign ready       = (pending_cnt < 4'(DEPTH));
  assign accept      = bus.issue_valid & ready & ~freeze & ~flush;
  assign full        = (count == 4'(DEPTH));
  assign head_vld    = (count != 4'd0);
  assign push        = ~freeze & ~flush & vld_p2 & (rd_p2 != 5'd0);
  assign pop         = head_vld & bus.wb_ready;
  assign wr_en       = push & (~full | pop);

  assign bus.issue_ready = ready;
  assign bus.wb_valid    = head_vld;
  assign bus.wb_rd       = head_vld ? mem_rd[rd_ptr]   : '0;
  assign bus.wb_tag      = head_vld ? mem_tag[rd_ptr]  : '0;
  assign bus.wb_data     = head_vld ? mem_data[rd_ptr] : '0;

  // Control: stage valids, FIFO pointers/count, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= 4'd0;
      err_overflow <= 1'b0;
    end else begin
      if (flush) begin
        vld_p0 <= 1'b0;
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else if (!freeze) begin
        vld_p0 <= accept;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
      end
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (pop)   rd_ptr <= next_ptr(rd_ptr);
      case ({wr_en, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (push && full && !pop) err_overflow <= 1'b1;
    end
  end

  // E1 -> E2 -> E3 shadow data; valid qualifies it, so no reset needed.
  always_ff @(posedge clk) begin
    if (!freeze) begin
      rd_p0  <= bus.issue_rd;
      tag_p0 <= bus.issue_tag;
      rd_p1  <= rd_p0;
      tag_p1 <= tag_p0;
      rd_p2  <= rd_p1;
      tag_p2 <= tag_p1;
    end
  end

  // E3 capture into the result FIFO.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_rd[wr_ptr]   <= rd_p2;
      mem_tag[wr_ptr]  <= tag_p2;
      mem_data[wr_ptr] <= mul_out;
    end
  end
endmodule

// File: tb/tb_exu_mul_wb.sv
// Directed bench for exu_mul_wb: a DEPTH=4 instance and a DEPTH=8 instance
// share the same stimulus; each scenario checks the instance it targets.
module tb_exu_mul_wb;
  logic        clk, rst, freeze, flush;
  logic [31:0] mul_out;
  logic [3:0]  pend_a, pend_b;
  logic        err_a, err_b;
  int          cyc;
  int          n_cmp, n_bad;

  exu_mul_wb_if #(.TAGW(4)) ia ();
  exu_mul_wb_if #(.TAGW(4)) ib ();

  assign ib.issue_valid = ia.issue_valid;
  assign ib.issue_rd    = ia.issue_rd;
  assign ib.issue_tag   = ia.issue_tag;
  assign ib.wb_ready    = ia.wb_ready;

  exu_mul_wb #(.DEPTH(4), .TAGW(4)) dut_a (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .mul_out(mul_out),
    .bus(ia.slave), .pending_cnt(pend_a), .err_overflow(err_a)
  );

  exu_mul_wb #(.DEPTH(8), .TAGW(4)) dut_b (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .mul_out(mul_out),
    .bus(ib.slave), .pending_cnt(pend_b), .err_overflow(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the next cycle; mul_out carries a cycle-stamped value.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mul_out = {24'hC0FFEE, cyc[7:0]};
  endtask

  task automatic idle();
    ia.issue_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
    ia.issue_valid = 1'b1;
    ia.issue_rd    = rd;
    ia.issue_tag   = tag;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    freeze = 1'b0;
    flush = 1'b0;
    ia.wb_ready = 1'b0;
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    mul_out = {24'hC0FFEE, 8'h00};
  endtask

  logic [4:0]  bp_rd   [4] = '{5'd11, 5'd12, 5'd13, 5'd14};
  logic [3:0]  bp_tag  [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
  logic [31:0] bp_data [4] = '{32'hC0FFEE04, 32'hC0FFEE05, 32'hC0FFEE06, 32'hC0FFEE0B};

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; mul_out = '0;
    ia.issue_valid = 1'b0; ia.issue_rd = '0; ia.issue_tag = '0; ia.wb_ready = 1'b0;
    #3;
    chk("rst_wb_valid", {31'd0, ia.wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, ia.wb_rd}, 32'd0);
    chk("rst_wb_tag", {28'd0, ia.wb_tag}, 32'd0);
    chk("rst_wb_data", ia.wb_data, 32'd0);
    chk("rst_issue_ready", {31'd0, ia.issue_ready}, 32'd1);
    chk("rst_pending", {28'd0, pend_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);

    // Single multiply: rd=5 tag=3, result during E3 (cycle 3).
    do_reset();
    issue(5'd5, 4'd3);
    tick(); idle();
    chk("single_pend_c1", {28'd0, pend_a}, 32'd1);
    tick();
    chk("single_pend_c2", {28'd0, pend_a}, 32'd1);
    tick();
    chk("single_pend_c3", {28'd0, pend_a}, 32'd1);
    chk("single_wbv_c3", {31'd0, ia.wb_valid}, 32'd0);
    tick();
    chk("single_wbv_c4", {31'd0, ia.wb_valid}, 32'd1);
    chk("single_rd", {27'd0, ia.wb_rd}, 32'd5);
    chk("single_tag", {28'd0, ia.wb_tag}, 32'd3);
    chk("single_data", ia.wb_data, 32'h12345678 ^ 32'h12345678 ^ 32'hC0FFEE03);
    chk("single_pend_c4", {28'd0, pend_a}, 32'd1);
    ia.wb_ready = 1'b1;
    tick();
    chk("single_wbv_c5", {31'd0, ia.wb_valid}, 32'd0);
    chk("single_pend_c5", {28'd0, pend_a}, 32'd0);

    // Freeze high during cycles 2..4: E3 slips to cycle 6, wb_valid at 7.
    do_reset();
    issue(5'd9, 4'd1);
    tick(); idle();
    tick(); freeze = 1'b1;
    tick();
    tick();
    tick(); freeze = 1'b0;
    tick();
    chk("frz_wbv_c6", {31'd0, ia.wb_valid}, 32'd0);
    tick();
    chk("frz_wbv_c7", {31'd0, ia.wb_valid}, 32'd1);
    chk("frz_rd", {27'd0, ia.wb_rd}, 32'd9);
    chk("frz_data", ia.wb_data, 32'hC0FFEE06);
    ia.wb_ready = 1'b1;
    tick();
    chk("frz_nodup_wbv", {31'd0, ia.wb_valid}, 32'd0);
    chk("frz_nodup_pend", {28'd0, pend_a}, 32'd0);

    // Back-pressure on DEPTH=4: four accepts, then issue_ready drops.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      issue(5'(10 + c), 4'(c));
      tick();
    end
    issue(5'd31, 4'd15);
    chk("bp_ready_c4", {31'd0, ia.issue_ready}, 32'd0);
    chk("bp_pend_c4", {28'd0, pend_a}, 32'd4);
    tick(); tick(); tick();
    chk("bp_ready_c7", {31'd0, ia.issue_ready}, 32'd0);
    chk("bp_pend_c7", {28'd0, pend_a}, 32'd4);
    chk("bp_head_rd", {27'd0, ia.wb_rd}, 32'd10);
    chk("bp_head_data", ia.wb_data, 32'hC0FFEE03);
    ia.wb_ready = 1'b1;
    tick();
    ia.wb_ready = 1'b0;
    chk("bp_pend_c8", {28'd0, pend_a}, 32'd3);
    chk("bp_ready_c8", {31'd0, ia.issue_ready}, 32'd1);
    issue(5'd14, 4'd4);
    tick(); idle();
    chk("bp_ready_c9", {31'd0, ia.issue_ready}, 32'd0);
    chk("bp_pend_c9", {28'd0, pend_a}, 32'd4);
    ia.wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_order_rd%0d", i), {27'd0, ia.wb_rd}, {27'd0, bp_rd[i]});
      chk($sformatf("bp_order_tag%0d", i), {28'd0, ia.wb_tag}, {28'd0, bp_tag[i]});
      chk($sformatf("bp_order_data%0d", i), ia.wb_data, bp_data[i]);
      tick();
    end
    chk("bp_drained", {31'd0, ia.wb_valid}, 32'd0);
    chk("bp_err", {31'd0, err_a}, 32'd0);

    // Flush on DEPTH=8 with E1/E2/E3 busy and two entries buffered.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      issue(5'(c + 1), 4'(c + 1));
      tick();
    end
    idle();
    chk("fl_pend_before", {28'd0, pend_b}, 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_pend_after", {28'd0, pend_b}, 32'd2);
    chk("fl_head0_rd", {27'd0, ib.wb_rd}, 32'd1);
    chk("fl_head0_data", ib.wb_data, 32'hC0FFEE03);
    ia.wb_ready = 1'b1;
    tick();
    chk("fl_head1_rd", {27'd0, ib.wb_rd}, 32'd2);
    chk("fl_head1_data", ib.wb_data, 32'hC0FFEE04);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("fl_empty%0d", i), {31'd0, ib.wb_valid}, 32'd0);
    end
    chk("fl_pend_end", {28'd0, pend_b}, 32'd0);

    // rd=0 completes silently; the following rd=7 lands one cycle later.
    do_reset();
    issue(5'd0, 4'd6);
    tick();
    issue(5'd7, 4'd8);
    tick(); idle();
    tick();
    tick();
    chk("rd0_wbv_c4", {31'd0, ia.wb_valid}, 32'd0);
    tick();
    chk("rd0_wbv_c5", {31'd0, ia.wb_valid}, 32'd1);
    chk("rd0_rd", {27'd0, ia.wb_rd}, 32'd7);
    chk("rd0_tag", {28'd0, ia.wb_tag}, 32'd8);
    chk("rd0_data", ia.wb_data, 32'hC0FFEE04);
    chk("rd0_pend", {28'd0, pend_a}, 32'd1);

    // Asynchronous reset with 3 buffered and 2 in flight (DEPTH=8).
    do_reset();
    for (int c = 0; c < 5; c++) begin
      issue(5'(c + 1), 4'(c));
      tick();
    end
    idle();
    tick();
    chk("mr_pend_before", {28'd0, pend_b}, 32'd5);
    chk("mr_wbv_before", {31'd0, ib.wb_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_wbv_now", {31'd0, ib.wb_valid}, 32'd0);
    chk("mr_pend_now", {28'd0, pend_b}, 32'd0);
    chk("mr_ready_now", {31'd0, ib.issue_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ia.wb_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("mr_stale%0d", i), {31'd0, ib.wb_valid}, 32'd0);
    end
    chk("mr_err", {31'd0, err_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
